// File: rtl/dac8728_pkg.sv
// Shared constants and FSM encoding for the DAC8728 channel scheduler.
package dac8728_pkg;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;
   localparam int TMR_W  = 7;

   localparam logic [4:0] DEF_CH_ADDR_BASE = 5'h08;
   localparam logic [4:0] ADDR_IDLE        = 5'h00;
   localparam int         DEF_DONE_TIMEOUT = 64;
   localparam int         DEF_LDAC_WIDTH   = 4;

   typedef enum logic [6:0] {
      ST_IDLE    = 7'b000_0001,
      ST_SNAP    = 7'b000_0010,
      ST_ISSUE   = 7'b000_0100,
      ST_WAIT_LO = 7'b000_1000,
      ST_WAIT_HI = 7'b001_0000,
      ST_LDAC    = 7'b010_0000,
      ST_FIN     = 7'b100_0000
   } state_t;

endpackage

// File: rtl/dac8728_channel_scheduler_if.sv
// Scheduler-to-driver bus: send/done handshake plus register address and data.
interface dac8728_channel_scheduler_if;

   logic               drv_send;
   logic        [4:0]  drv_add;
   logic signed [15:0] drv_data;
   logic               drv_done;

   modport master (output drv_send, drv_add, drv_data, input drv_done);
   modport slave  (input drv_send, drv_add, drv_data, output drv_done);

endinterface

// File: rtl/dac8728_channel_scheduler_ch_pick.sv
// Combinational lowest-set-bit picker over the frame's channel mask.
module dac8728_ch_pick
   import dac8728_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   output logic [CH_W-1:0]   idx,
   output logic              valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = CH_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dac8728_channel_scheduler.sv
// Shadow/dirty store for 8 DAC8728 channels, flushed through the bus driver on update_req.
// Optional LDAC pulse at the end of a successful frame: define DAC8728_LDAC_PULSE_EN.
//
// state   | meaning
// IDLE    | no frame; waits for update_req or a pending request
// SNAP    | latch dirty bits into the frame mask
// ISSUE   | load address/data of lowest masked channel, pulse send
// WAIT_LO | wait for driver done to drop
// WAIT_HI | wait for driver done to return high
// LDAC    | hold dac_ldac_n low for LDAC_WIDTH cycles
// FIN     | frame_done pulse, back to IDLE
module dac8728_channel_scheduler
   import dac8728_pkg::*;
#(
   parameter logic [4:0] CH_ADDR_BASE = DEF_CH_ADDR_BASE,
   parameter int         DONE_TIMEOUT = DEF_DONE_TIMEOUT,
   parameter int         LDAC_WIDTH   = DEF_LDAC_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ch_wr_en,
   input  logic [CH_W-1:0]             ch_wr_sel,
   input  logic signed [15:0]          ch_wr_data,
   input  logic                        update_req,
   input  logic                        err_clr,
   output logic                        busy,
   output logic                        frame_done,
   output logic                        err_timeout,
   output logic                        dac_ldac_n,
   dac8728_channel_scheduler_if.master drv
);

   state_t             state, state_nxt;
   logic signed [15:0] shadow [NUM_CH];
   logic [NUM_CH-1:0]  dirty, dirty_nxt, mask;
   logic               pending;
   logic [CH_W-1:0]    cur_idx, pick_idx;
   logic               pick_vld;
   logic [TMR_W-1:0]   tmr;
   logic               tmo;
   logic               send_q;
   logic [4:0]         add_q;
   logic signed [15:0] data_q;

   dac8728_ch_pick u_pick (
      .mask  (mask),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_comb begin
      state_nxt = state;
      tmo       = 1'b0;
      case (state)
         ST_IDLE:    if (update_req || pending) state_nxt = ST_SNAP;
         ST_SNAP:    state_nxt = (dirty == '0) ? ST_FIN : ST_ISSUE;
         ST_ISSUE:   state_nxt = pick_vld ? ST_WAIT_LO : ST_FIN;
         ST_WAIT_LO: begin
            if (!drv.drv_done) begin
               state_nxt = ST_WAIT_HI;
            end else if (tmr == '0) begin
               tmo       = 1'b1;
               state_nxt = ST_FIN;
            end
         end
         ST_WAIT_HI: begin
            if (drv.drv_done) begin
               if (mask != '0) begin
                  state_nxt = ST_ISSUE;
               end else begin
`ifdef DAC8728_LDAC_PULSE_EN
                  state_nxt = ST_LDAC;
`else
                  state_nxt = ST_FIN;
`endif
               end
            end else if (tmr == '0) begin
               tmo       = 1'b1;
               state_nxt = ST_FIN;
            end
         end
         ST_LDAC:    if (tmr == '0) state_nxt = ST_FIN;
         ST_FIN:     state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // A host write in the ISSUE cycle re-dirties its channel; an aborted channel is re-dirtied too.
   always_comb begin
      dirty_nxt = dirty;
      if (state == ST_ISSUE) dirty_nxt[pick_idx] = 1'b0;
      if (tmo)               dirty_nxt[cur_idx]  = 1'b1;
      if (ch_wr_en)          dirty_nxt[ch_wr_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
         dirty       <= '0;
         mask        <= '0;
         pending     <= 1'b0;
         cur_idx     <= '0;
         tmr         <= '0;
         err_timeout <= 1'b0;
         send_q      <= 1'b0;
         add_q       <= ADDR_IDLE;
         data_q      <= '0;
      end else begin
         state  <= state_nxt;
         dirty  <= dirty_nxt;
         send_q <= (state == ST_ISSUE) && pick_vld;
         if (ch_wr_en) shadow[ch_wr_sel] <= ch_wr_data;

         if (state == ST_IDLE && state_nxt == ST_SNAP) pending <= 1'b0;
         else if (update_req && state != ST_IDLE)      pending <= 1'b1;

         if (state == ST_SNAP) mask <= dirty;
         else if (state == ST_ISSUE) mask[pick_idx] <= 1'b0;

         if (state == ST_ISSUE) begin
            cur_idx <= pick_idx;
            add_q   <= CH_ADDR_BASE + 5'(pick_idx);
            data_q  <= shadow[pick_idx];
         end else if (state == ST_FIN) begin
            add_q   <= ADDR_IDLE;
            data_q  <= '0;
         end

         if (state_nxt != state && (state_nxt == ST_WAIT_LO || state_nxt == ST_WAIT_HI))
            tmr <= TMR_W'(DONE_TIMEOUT - 1);
         else if (state_nxt != state && state_nxt == ST_LDAC)
            tmr <= TMR_W'(LDAC_WIDTH - 1);
         else if (tmr != '0)
            tmr <= tmr - 1'b1;

         if (tmo)          err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

   assign busy         = (state != ST_IDLE);
   assign frame_done   = (state == ST_FIN);
   assign drv.drv_send = send_q;
   assign drv.drv_add  = add_q;
   assign drv.drv_data = data_q;

`ifdef DAC8728_LDAC_PULSE_EN
   assign dac_ldac_n = (state != ST_LDAC);
`else
   assign dac_ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_dac8728_channel_scheduler.sv
// Scoreboard bench: random and directed frames checked against a shadow/dirty reference model.
module tb_dac8728_channel_scheduler;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ch_wr_en = 1'b0;
   logic [2:0]        ch_wr_sel = '0;
   logic signed [15:0] ch_wr_data = '0;
   logic              update_req = 1'b0;
   logic              err_clr = 1'b0;
   logic              busy, frame_done, err_timeout, dac_ldac_n;

   dac8728_channel_scheduler_if bus ();

   dac8728_channel_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ch_wr_en    (ch_wr_en),
      .ch_wr_sel   (ch_wr_sel),
      .ch_wr_data  (ch_wr_data),
      .update_req  (update_req),
      .err_clr     (err_clr),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_timeout (err_timeout),
      .dac_ldac_n  (dac_ldac_n),
      .drv         (bus)
   );

   always #50 clk = ~clk;

   typedef struct packed {
      logic [4:0]  add;
      logic [15:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [15:0] m_shadow [8];
   bit          m_dirty [8];
   int          n_cmp = 0, n_bad = 0;
   int          send_cnt = 0, fd_cnt = 0, ldac_low_total = 0;
   int          drv_cnt = -1;
   bit          hold_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Driver model: done falls 2 cycles after send and rises 12 cycles after it.
   always @(negedge clk) begin
      if (!rst_n) begin
         drv_cnt      = -1;
         bus.drv_done = 1'b1;
      end else begin
         if (bus.drv_send && !hold_done) drv_cnt = 0;
         else if (drv_cnt >= 0)          drv_cnt++;
         if (drv_cnt == 2) bus.drv_done = 1'b0;
         if (drv_cnt == 12) begin
            bus.drv_done = 1'b1;
            drv_cnt      = -1;
         end
      end
   end

   always @(negedge clk) begin
      xfer_t e;
      if (rst_n) begin
         if (!dac_ldac_n) ldac_low_total++;
         if (bus.drv_send) begin
            send_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_send: got add %0h, expected no send", bus.drv_add);
            end else begin
               e = exp_q.pop_front();
               chk("drv_add", {27'h0, bus.drv_add}, {27'h0, e.add});
               chk("drv_data", {16'h0, bus.drv_data}, {16'h0, e.data});
            end
         end
         if (frame_done) begin
            fd_cnt++;
            chk("queue_empty_at_frame_done", exp_q.size(), 0);
         end
      end
   end

   task automatic host_wr(input int ch, input logic [15:0] d);
      @(negedge clk);
      ch_wr_en   = 1'b1;
      ch_wr_sel  = ch[2:0];
      ch_wr_data = d;
      m_shadow[ch] = d;
      m_dirty[ch]  = 1'b1;
      @(negedge clk);
      ch_wr_en = 1'b0;
   endtask

   task automatic req();
      @(negedge clk);
      update_req = 1'b1;
      @(negedge clk);
      update_req = 1'b0;
   endtask

   // Every dirty channel is written once, lowest index first.
   function automatic void flush();
      xfer_t e;
      for (int k = 0; k < 8; k++) begin
         if (m_dirty[k]) begin
            e.add  = 5'h08 + 5'(k);
            e.data = m_shadow[k];
            exp_q.push_back(e);
            m_dirty[k] = 1'b0;
         end
      end
   endfunction

   task automatic wait_fd(input int target, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         if (fd_cnt >= target) break;
         @(negedge clk);
      end
      chk(nm, {31'h0, fd_cnt >= target}, 32'h1);
   endtask

   task automatic wait_send(input int target, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         if (send_cnt >= target) break;
         @(negedge clk);
      end
      chk(nm, {31'h0, send_cnt >= target}, 32'h1);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, {31'h0, busy}, 0);
      chk({nm, "_frame_done"}, {31'h0, frame_done}, 0);
      chk({nm, "_err"}, {31'h0, err_timeout}, 0);
      chk({nm, "_send"}, {31'h0, bus.drv_send}, 0);
      chk({nm, "_add"}, {27'h0, bus.drv_add}, 0);
      chk({nm, "_data"}, {16'h0, bus.drv_data}, 0);
      chk({nm, "_ldac_n"}, {31'h0, dac_ldac_n}, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, s0, s1, n, low, prev_low;
      for (int k = 0; k < 8; k++) begin
         m_shadow[k] = '0;
         m_dirty[k]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // T1: two channels, ascending order, ch5 carries -1
      f0 = fd_cnt;
      host_wr(2, 16'h1234);
      host_wr(5, 16'hFFFF);
      req();
      flush();
      chk("t1_busy", {31'h0, busy}, 1);
      wait_fd(f0 + 1, 200, "t1_frame_done");

      // T2: empty frame, frame_done exactly two cycles after the request
      repeat (2) @(negedge clk);
      s0 = send_cnt;
      update_req = 1'b1;
      @(negedge clk);
      update_req = 1'b0;
      chk("t2_fd_early", {31'h0, frame_done}, 0);
      @(negedge clk);
      chk("t2_fd_at_2", {31'h0, frame_done}, 1);
      @(negedge clk);
      chk("t2_fd_pulse", {31'h0, frame_done}, 0);
      chk("t2_busy_end", {31'h0, busy}, 0);
      chk("t2_no_send", send_cnt, s0);

      // T3: full frame, merged mid-frame request, write during ch3's transfer
      f0 = fd_cnt;
      for (int k = 0; k < 8; k++) host_wr(k, 16'($urandom));
      req();
      flush();
      s0 = send_cnt;
      wait_send(s0 + 1, 100, "t3_first_send");
      req();
      wait_send(s0 + 4, 200, "t3_ch3_send");
      host_wr(0, 16'h0100);
      wait_fd(f0 + 1, 400, "t3_frame1_done");
      @(negedge clk);
      flush();
      wait_fd(f0 + 2, 200, "t3_frame2_done");
      chk("t3_send_total", send_cnt - s0, 9);

      // T4: driver never drops done -> timeout abort, channel stays dirty, retry
      hold_done = 1'b1;
      f0 = fd_cnt;
      host_wr(6, 16'($urandom));
      req();
      flush();
      m_dirty[6] = 1'b1;
      wait_fd(f0 + 1, 300, "t4_abort_done");
      @(negedge clk);
      chk("t4_err_set", {31'h0, err_timeout}, 1);
      chk("t4_idle_after_abort", {31'h0, busy}, 0);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t4_err_cleared", {31'h0, err_timeout}, 0);
      hold_done = 1'b0;
      req();
      flush();
      wait_fd(f0 + 2, 200, "t4_retry_done");
      chk("t4_err_after_retry", {31'h0, err_timeout}, 0);

      // Randomized frames with writes only while idle
      for (int it = 0; it < 6; it++) begin
         repeat (2) @(negedge clk);
         f0 = fd_cnt;
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) host_wr($urandom_range(0, 7), 16'($urandom));
         req();
         flush();
         wait_fd(f0 + 1, 400, "rand_frame_done");
      end

`ifdef DAC8728_LDAC_PULSE_EN
      // T6: LDAC low for 4 cycles after done rises, then frame_done
      repeat (2) @(negedge clk);
      host_wr(1, 16'($urandom));
      flush();
      @(negedge clk);
      update_req = 1'b1;
      low = 0;
      prev_low = 0;
      s1 = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         update_req = 1'b0;
         if (!dac_ldac_n && !bus.drv_done) s1 = 1;
         if (frame_done) break;
         prev_low = !dac_ldac_n;
         if (!dac_ldac_n) low++;
      end
      chk("t6_ldac_low_cycles", low, 4);
      chk("t6_ldac_right_before_fd", prev_low, 1);
      chk("t6_ldac_high_at_fd", {31'h0, dac_ldac_n}, 1);
      chk("t6_ldac_only_after_done", s1, 0);
`else
      chk("ldac_stays_high", ldac_low_total, 0);
`endif

      // T5: reset during WAIT_HI of the third channel
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) host_wr(k, 16'($urandom));
      req();
      flush();
      s0 = send_cnt;
      wait_send(s0 + 3, 200, "t5_third_send");
      repeat (5) @(negedge clk);
      chk("t5_in_wait_hi", {31'h0, bus.drv_done}, 0);
      rst_n = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         m_shadow[k] = '0;
         m_dirty[k]  = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_outputs("t5");
      s1 = send_cnt;
      repeat (100) @(negedge clk);
      chk("t5_no_send_after_reset", send_cnt, s1);
      chk("t5_idle_after_reset", {31'h0, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
